draw_scheduler: RTL and testbench
=================================

Name: draw_scheduler

Overview:
- Shares the single VGA pixel-plot path between the game FSM's draw requesters (menu, player select, move select, tackle, special, win screens).
- Each requester raises a draw request. The scheduler arbitrates between them, fetches that screen's rectangle descriptor, and walks the rectangle pixel by pixel, driving sprite-ROM addresses and plot/x/y/colour.
- Pulses a per-requester done when the rectangle is complete. Sits between the control FSM and the VGA adapter and sprite ROMs.

Parameters:
- NREQ, 10, number of draw requesters.
- XW, 8, x coordinate width (screen 160 wide).
- YW, 7, y coordinate width (screen 120 tall).
- AW, 15, sprite ROM address width.
- CW, 3, colour width.
- TRANSPARENT_COLOR, 3'b000, colour suppressed when the optional feature is enabled.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous active-low reset
- req  in  NREQ  level draw requests, bit i = requester i
- done  out  NREQ  one-cycle pulse on bit i when requester i's draw completes
- busy  out  1  high from grant until the done pulse, inclusive
- desc_idx  out  4  descriptor table index (= granted requester)
- desc_x0  in  XW  rectangle origin x; valid one cycle after desc_idx changes
- desc_y0  in  YW  rectangle origin y
- desc_w  in  XW  rectangle width in pixels
- desc_h  in  YW  rectangle height in pixels
- desc_base  in  AW  sprite ROM base address
- rom_addr  out  AW  sprite ROM address (synchronous ROM, 1-cycle latency)
- rom_color  in  CW  ROM data, valid one cycle after rom_addr
- plot  out  1  write-enable to the VGA adapter
- x  out  XW  pixel x
- y  out  YW  pixel y
- color  out  CW  pixel colour

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE.
  - done, busy, plot, x, y, color, rom_addr, desc_idx all 0.
  - Round-robin pointer 0; all served flags cleared.
- States:
  - IDLE: choose an eligible requester and go to FETCH.
  - FETCH: drive desc_idx for 1 cycle.
  - LOAD: latch the descriptor. Go to DONE if desc_w==0 or desc_h==0, else to DRAW.
  - DRAW: issue one rom_addr per cycle.
  - FLUSH: 1 cycle to emit the last pixel.
  - DONE: pulse done[g] for 1 cycle, then go to IDLE.
- Eligibility: req[i]=1 and served[i]=0.
  - served[i] is set on done[i].
  - served[i] clears when req[i] is sampled low.
  - A request held high after its done is therefore not redrawn.
- Arbitration:
  - Round-robin, starting search at pointer; pointer becomes g+1 (mod NREQ) after grant.
  - Simultaneous requests are served one at a time in round-robin order.
- Walk order: raster, cx from 0..w-1 inner, cy from 0..h-1 outer.
  - rom_addr = base + cy*w + cx, implemented as an incrementing counter (no multiplier).
- Pipeline: rom_addr issued in cycle N produces plot=1 with x=x0+cx, y=y0+cy, color=rom_color in cycle N+1.
- Clipping: x0+cx and y0+cy are computed at XW+1/YW+1 bits.
  - A pixel with x>=160 or y>=120 still consumes its cycle but has plot=0.
- Latency: w*h pixels finish in w*h+4 cycles from grant (FETCH, LOAD, w*h DRAW, FLUSH, DONE). done fires on the cycle after the last plot.
- If req[g] falls mid-draw, the draw still completes and done[g] still pulses.
- Reset mid-draw aborts immediately: no done, plot=0 from the reset edge.
- plot=0 in every state except the cycle following a DRAW issue.

Optional Feature:
- Macro DRAW_SCHEDULER_TRANSPARENT_EN.
- Defined: a pixel whose rom_color==TRANSPARENT_COLOR has plot=0 (x/y/color still update) and still consumes its cycle.
- Not defined: every in-bounds pixel is plotted regardless of colour.

Test Plan:
- req[0]=1, descriptor x0=10,y0=20,w=3,h=2,base=100 -> 6 plots:
  - rom_addr 100..105.
  - (x,y) = (10,20),(11,20),(12,20),(10,21),(11,21),(12,21).
  - done[0] pulses once, 10 cycles after grant.
- req[2] and req[5] both rise in the same cycle, pointer=0 -> req[2] drawn and done[2] first; then req[5] drawn and done[5]; no overlapping plots.
- req[3] held high after done[3] -> no second draw. Drop req[3] for 1 cycle and raise it again -> second draw and second done[3].
- Descriptor x0=158, w=4, h=1 -> plot=1 for x=158,159 only; 4 ROM reads; done pulses.
- w=0 -> no plot; done pulses 3 cycles after grant. Separately, reset asserted mid-draw -> plot and busy drop immediately, no done; after release the scheduler returns to IDLE.
- With DRAW_SCHEDULER_TRANSPARENT_EN, 2x1 sprite with colours {000,101} -> single plot at cx=1 with color=101. Without the macro -> 2 plots.

Source files
------------

// File: rtl/draw_scheduler_if.sv
// Draw scheduler bus: requests/done, descriptor table port,
// sprite ROM port and VGA pixel-plot port, grouped for one draw path.
//   master: scheduler side (drives done/busy/desc_idx/rom_addr/plot/x/y/color)
//   slave : environment side (drives req/desc_*/rom_color)
interface draw_scheduler_if #(
  parameter int NREQ = 10,
  parameter int XW   = 8,
  parameter int YW   = 7,
  parameter int AW   = 15,
  parameter int CW   = 3
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] done;
  logic            busy;
  logic [3:0]      desc_idx;
  logic [XW-1:0]   desc_x0;
  logic [YW-1:0]   desc_y0;
  logic [XW-1:0]   desc_w;
  logic [YW-1:0]   desc_h;
  logic [AW-1:0]   desc_base;
  logic [AW-1:0]   rom_addr;
  logic [CW-1:0]   rom_color;
  logic            plot;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic [CW-1:0]   color;

  modport master (
    input  req, desc_x0, desc_y0, desc_w, desc_h,
    input  desc_base, rom_color,
    output done, busy, desc_idx, rom_addr,
    output plot, x, y, color
  );

  modport slave (
    output req, desc_x0, desc_y0, desc_w, desc_h,
    output desc_base, rom_color,
    input  done, busy, desc_idx, rom_addr,
    input  plot, x, y, color
  );
endinterface

// File: rtl/draw_scheduler.sv
// Draw scheduler: round-robin arbiter over NREQ draw requesters that
// fetches a rectangle descriptor and rasters it through the sprite ROM
// into the VGA plot port, pulsing done[g] when the rectangle finishes.
// Ports: clock, reset (async, active low), bus (draw_scheduler_if.master).
// Optional: `define DRAW_SCHEDULER_TRANSPARENT_EN suppresses plot for
// pixels whose ROM colour equals TRANSPARENT_COLOR.
module draw_scheduler #(
  parameter int NREQ = 10,
  parameter int XW   = 8,
  parameter int YW   = 7,
  parameter int AW   = 15,
  parameter int CW   = 3
`ifdef DRAW_SCHEDULER_TRANSPARENT_EN
  ,
  parameter logic [CW-1:0] TRANSPARENT_COLOR = 3'b000
`endif
) (
  input logic             clock,
  input logic             reset,
  draw_scheduler_if.master bus
);

  localparam int SCR_W = 160;
  localparam int SCR_H = 120;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_DRAW,
    S_FLUSH,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [3:0]      ptr_q, gnt_q, pick;
  logic [NREQ-1:0] served_q, elig, done_v;
  logic            found;
  logic [XW-1:0]   x0_q, w_q, cx_q, x_q;
  logic [YW-1:0]   y0_q, h_q, cy_q, y_q;
  logic [AW-1:0]   addr_q;
  logic            pix_v_q, pix_in_q;
  logic [XW:0]     xs;
  logic [YW:0]     ys;
  logic            row_end, last, empty, transp;
  int              rr_best, rr_d;

  assign elig  = bus.req & ~served_q;
  assign found = |elig;

  // Pick the eligible requester closest to ptr in round-robin order.
  always_comb begin
    rr_best = NREQ;
    rr_d    = 0;
    pick    = '0;
    for (int i = 0; i < NREQ; i++) begin
      rr_d = (i - int'(ptr_q) + NREQ) % NREQ;
      if (elig[i] && rr_d < rr_best) begin
        rr_best = rr_d;
        pick    = 4'(i);
      end
    end
  end

  assign row_end = (cx_q == w_q - XW'(1));
  assign last    = row_end && (cy_q == h_q - YW'(1));
  assign empty   = (bus.desc_w == '0) || (bus.desc_h == '0);

  // One extra bit so off-screen pixels are detected, not wrapped.
  assign xs = {1'b0, x0_q} + {1'b0, cx_q};
  assign ys = {1'b0, y0_q} + {1'b0, cy_q};

`ifdef DRAW_SCHEDULER_TRANSPARENT_EN
  assign transp = (bus.rom_color == TRANSPARENT_COLOR);
`else
  assign transp = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    done_v  = '0;
    unique case (state_q)
      S_IDLE:  if (found) state_d = S_FETCH;
      S_FETCH: state_d = S_LOAD;
      S_LOAD:  state_d = empty ? S_DONE : S_DRAW;
      S_DRAW:  if (last) state_d = S_FLUSH;
      S_FLUSH: state_d = S_DONE;
      S_DONE: begin
        state_d = S_IDLE;
        done_v  = NREQ'(1) << gnt_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_q    <= '0;
      gnt_q    <= '0;
      served_q <= '0;
      x0_q     <= '0;
      y0_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      addr_q   <= '0;
      pix_v_q  <= 1'b0;
      pix_in_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      // A dropped request re-arms its requester.
      served_q <= (served_q | done_v) & bus.req;
      pix_v_q  <= 1'b0;
      if (state_q == S_IDLE && found) begin
        gnt_q <= pick;
        ptr_q <= (pick == 4'(NREQ - 1)) ? '0 : pick + 4'd1;
      end
      if (state_q == S_LOAD) begin
        x0_q   <= bus.desc_x0;
        y0_q   <= bus.desc_y0;
        w_q    <= bus.desc_w;
        h_q    <= bus.desc_h;
        addr_q <= bus.desc_base;
        cx_q   <= '0;
        cy_q   <= '0;
      end
      if (state_q == S_DRAW) begin
        // Raster order makes the ROM address a plain counter.
        addr_q   <= addr_q + AW'(1);
        pix_v_q  <= 1'b1;
        pix_in_q <= (xs < (XW+1)'(SCR_W)) &&
                    (ys < (YW+1)'(SCR_H));
        x_q      <= xs[XW-1:0];
        y_q      <= ys[YW-1:0];
        if (row_end) begin
          cx_q <= '0;
          cy_q <= cy_q + YW'(1);
        end else begin
          cx_q <= cx_q + XW'(1);
        end
      end
    end
  end

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = done_v;
  assign bus.desc_idx = gnt_q;
  assign bus.rom_addr = addr_q;
  assign bus.plot     = pix_v_q & pix_in_q & ~transp;
  assign bus.x        = x_q;
  assign bus.y        = y_q;
  // ROM data lands the cycle after its address, aligned with x/y.
  assign bus.color    = pix_v_q ? bus.rom_color : '0;

endmodule

// File: tb/tb_draw_scheduler.sv
// Bench for draw_scheduler: directed cases plus random requests,
// checked cycle by cycle against a timeline model of each draw.
module tb_draw_scheduler;
  localparam int NREQ = 10;

  logic clock = 1'b0;
  logic reset = 1'b0;

  draw_scheduler_if #(.NREQ(NREQ)) bus ();

  draw_scheduler #(.NREQ(NREQ)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [2:0]  mem [0:32767];
  logic [7:0]  tx0 [NREQ];
  logic [6:0]  ty0 [NREQ];
  logic [7:0]  tw  [NREQ];
  logic [6:0]  th  [NREQ];
  logic [14:0] tbs [NREQ];

  // Synchronous descriptor table and sprite ROM.
  always @(posedge clock) begin
    bus.rom_color <= mem[bus.rom_addr];
    if (bus.desc_idx < NREQ) begin
      bus.desc_x0   <= tx0[bus.desc_idx];
      bus.desc_y0   <= ty0[bus.desc_idx];
      bus.desc_w    <= tw[bus.desc_idx];
      bus.desc_h    <= th[bus.desc_idx];
      bus.desc_base <= tbs[bus.desc_idx];
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pc = 0;
  int dcnt [NREQ];

  bit              job_v = 1'b0;
  int              j_start, j_done, j_g, j_n, j_w, j_x0, j_y0;
  logic [14:0]     j_base;
  logic [NREQ-1:0] served_m = '0;
  int              ptr_m = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic setd(input int i, input int x0, input int y0,
                      input int w, input int h, input int base,
                      input bit fill);
    tx0[i] = 8'(x0);
    ty0[i] = 7'(y0);
    tw[i]  = 8'(w);
    th[i]  = 7'(h);
    tbs[i] = 15'(base);
    if (fill)
      for (int k = 0; k < w * h; k++)
        mem[15'(base + k)] = 3'($urandom_range(1, 7));
  endtask

  // Expected outputs for the current cycle, from the draw timeline:
  // grant cycle s, FETCH s+1, LOAD s+2, DRAW s+3.., plot s+4..,
  // done at s+n+4 (s+3 for an empty rectangle).
  task automatic observe();
    logic [NREQ-1:0] dexp;
    int k, xs, ys;
    bit pexp;
    logic [2:0] col;
    chk("busy", 32'(bus.busy),
        32'(job_v && cyc > j_start && cyc <= j_done));
    dexp = (job_v && cyc == j_done) ? NREQ'(1) << j_g : '0;
    chk("done", 32'(bus.done), 32'(dexp));
    for (int i = 0; i < NREQ; i++)
      if (bus.done[i] === 1'b1) dcnt[i]++;
    if (bus.plot === 1'b1) pc++;
    if (job_v && cyc == j_start + 1)
      chk("desc_idx", 32'(bus.desc_idx), j_g);
    k = cyc - j_start - 3;
    if (job_v && k >= 0 && k < j_n)
      chk("rom_addr", 32'(bus.rom_addr), 32'(15'(j_base + k)));
    k = cyc - j_start - 4;
    if (job_v && k >= 0 && k < j_n) begin
      xs = j_x0 + k % j_w;
      ys = j_y0 + k / j_w;
      col = mem[15'(j_base + k)];
      pexp = (xs < 160) && (ys < 120);
`ifdef DRAW_SCHEDULER_TRANSPARENT_EN
      if (col == 3'b000) pexp = 1'b0;
`endif
      chk("plot", 32'(bus.plot), 32'(pexp));
      chk("x", 32'(bus.x), xs & 255);
      chk("y", 32'(bus.y), ys & 127);
      chk("color", 32'(bus.color), 32'(col));
    end else begin
      chk("plot", 32'(bus.plot), 0);
    end
  endtask

  // Model the clock edge that follows: served flags and new grants.
  task automatic model_edge();
    logic [NREQ-1:0] old_s, dv;
    bit idle;
    int i;
    if (!reset) begin
      served_m = '0;
      ptr_m = 0;
      job_v = 1'b0;
      return;
    end
    idle = !job_v;
    old_s = served_m;
    dv = (job_v && cyc == j_done) ? NREQ'(1) << j_g : '0;
    served_m = (served_m | dv) & bus.req;
    if (job_v && cyc >= j_done) job_v = 1'b0;
    if (idle) begin
      for (int d = 0; d < NREQ; d++) begin
        i = (ptr_m + d) % NREQ;
        if (!job_v && bus.req[i] && !old_s[i]) begin
          job_v = 1'b1;
          j_g = i;
          j_start = cyc;
          j_x0 = int'(tx0[i]);
          j_y0 = int'(ty0[i]);
          j_w = int'(tw[i]);
          j_n = int'(tw[i]) * int'(th[i]);
          j_base = tbs[i];
          j_done = cyc + ((j_n == 0) ? 3 : j_n + 4);
          ptr_m = (i + 1) % NREQ;
        end
      end
    end
  endtask

  task automatic cycle(input logic [NREQ-1:0] r);
    @(negedge clock);
    cyc++;
    observe();
    bus.req = r;
    model_edge();
  endtask

  task automatic clr();
    pc = 0;
    for (int i = 0; i < NREQ; i++) dcnt[i] = 0;
  endtask

  initial begin
    logic [NREQ-1:0] r;
    for (int a = 0; a < 32768; a++) mem[a] = 3'($urandom);
    for (int i = 0; i < NREQ; i++) setd(i, 0, 0, 0, 0, 0, 1'b0);
    bus.req = '0;
    clr();

    repeat (3) cycle('0);
    chk("rst_x", 32'(bus.x), 0);
    chk("rst_y", 32'(bus.y), 0);
    chk("rst_color", 32'(bus.color), 0);
    chk("rst_rom_addr", 32'(bus.rom_addr), 0);
    chk("rst_desc_idx", 32'(bus.desc_idx), 0);
    reset = 1'b1;
    repeat (2) cycle('0);

    // 3x2 sprite at (10,20), base 100
    setd(0, 10, 20, 3, 2, 100, 1'b1);
    clr();
    repeat (16) cycle(10'h001);
    chk("t1_plots", pc, 6);
    chk("t1_done", dcnt[0], 1);
    repeat (2) cycle('0);

    // reset in the middle of a draw
    setd(1, 5, 5, 8, 4, 300, 1'b1);
    clr();
    repeat (9) cycle(10'h002);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_plot", 32'(bus.plot), 0);
    chk("rst_mid_busy", 32'(bus.busy), 0);
    chk("rst_mid_done", 32'(bus.done), 0);
    job_v = 1'b0;
    served_m = '0;
    ptr_m = 0;
    repeat (2) cycle('0);
    reset = 1'b1;
    repeat (3) cycle('0);
    chk("rst_mid_nodone", dcnt[1], 0);

    // simultaneous requests 2 and 5 from pointer 0
    setd(2, 0, 0, 2, 2, 400, 1'b1);
    setd(5, 100, 100, 3, 1, 450, 1'b1);
    clr();
    repeat (30) cycle(10'h024);
    chk("t2_done2", dcnt[2], 1);
    chk("t2_done5", dcnt[5], 1);
    chk("t2_plots", pc, 7);
    repeat (2) cycle('0);

    // held request is not redrawn until it drops
    setd(3, 40, 40, 2, 2, 700, 1'b1);
    clr();
    repeat (20) cycle(10'h008);
    chk("t3_once", dcnt[3], 1);
    cycle('0);
    repeat (20) cycle(10'h008);
    chk("t3_twice", dcnt[3], 2);
    repeat (2) cycle('0);

    // right-edge clipping
    setd(4, 158, 50, 4, 1, 500, 1'b1);
    clr();
    repeat (15) cycle(10'h010);
    chk("t4_plots", pc, 2);
    chk("t4_done", dcnt[4], 1);
    repeat (2) cycle('0);

    // empty rectangle
    setd(6, 20, 20, 0, 3, 600, 1'b1);
    clr();
    repeat (8) cycle(10'h040);
    chk("t5_plots", pc, 0);
    chk("t5_done", dcnt[6], 1);
    repeat (2) cycle('0);

    // 2x1 sprite with a transparent first pixel
    setd(7, 30, 30, 2, 1, 200, 1'b0);
    mem[200] = 3'b000;
    mem[201] = 3'b101;
    clr();
    repeat (10) cycle(10'h080);
`ifdef DRAW_SCHEDULER_TRANSPARENT_EN
    chk("t7_plots", pc, 1);
`else
    chk("t7_plots", pc, 2);
`endif
    repeat (2) cycle('0);

    // random request traffic over random descriptors
    for (int i = 0; i < NREQ; i++)
      setd(i, $urandom_range(0, 170), $urandom_range(0, 127),
           $urandom_range(0, 8), $urandom_range(0, 5),
           $urandom_range(0, 32767), 1'b0);
    for (int n = 0; n < 4000; n++) begin
      r = bus.req;
      if ($urandom_range(0, 5) == 0)
        r[$urandom_range(0, NREQ - 1)] ^= 1'b1;
      cycle(r);
    end
    repeat (80) cycle('0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
